// File: rtl/byte_copy_arbiter.sv
// Arbitrates one memory write port between host byte writes and a masked block-copy engine.
// The copy engine yields to the host, but a starvation guard forces it a grant after STARVE-1 consecutive blocked cycles.
module byte_copy_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 32,
  parameter int STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW/8-1:0]   wr_be,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_valid,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_rvalid,
  input  logic              cp_start,
  input  logic [AW-1:0]     cp_src,
  input  logic [AW-1:0]     cp_dst,
  input  logic [AW:0]       cp_len,
  input  logic [DW/8-1:0]   cp_mask,
  output logic              cp_busy,
  output logic              cp_done
);

  localparam int NB = DW / 8;
  localparam int SW = (STARVE > 1) ? $clog2(STARVE) : 1;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem [2**AW];
  logic [AW-1:0]   src_q, dst_q;
  logic [AW:0]     len_q, idx_q;
  logic [NB-1:0]   mask_q;
  logic [SW-1:0]   starve_q;

  logic [AW-1:0]   cp_rd_addr, cp_wr_addr;
  logic [DW-1:0]   src_word, dst_word, cp_wdata;
  logic            starve_sat, copy_grant, last_entry;

  // Addresses wrap naturally through AW-bit truncation.
  assign cp_rd_addr = src_q + idx_q[AW-1:0];
  assign cp_wr_addr = dst_q + idx_q[AW-1:0];
  assign src_word   = mem[cp_rd_addr];
  assign dst_word   = mem[cp_wr_addr];

  assign starve_sat = (starve_q == SW'(STARVE - 1));
  assign copy_grant = (state_q == COPY) && (!wr_valid || starve_sat);
  assign wr_ready   = wr_valid && !copy_grant;
  assign last_entry = (idx_q == len_q - (AW+1)'(1));

  always_comb begin
    cp_wdata = dst_word;
    for (int b = 0; b < NB; b++) begin
      if (mask_q[b]) cp_wdata[b*8 +: 8] = src_word[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cp_busy = 1'b0;
    cp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cp_start) state_d = (cp_len == '0) ? DONE : COPY;
      end
      COPY: begin
        cp_busy = 1'b1;
        if (copy_grant && last_entry) state_d = DONE;
      end
      DONE: begin
        cp_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      idx_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cp_start) begin
        src_q  <= cp_src;
        dst_q  <= cp_dst;
        len_q  <= cp_len;
        mask_q <= cp_mask;
        idx_q  <= '0;
      end else if (copy_grant) begin
        idx_q <= idx_q + (AW+1)'(1);
      end
      if (state_q != COPY || copy_grant) starve_q <= '0;
      else if (wr_valid && !starve_sat)  starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= '0;
      rd_rvalid <= 1'b0;
    end else begin
      rd_rvalid <= rd_valid;
      if (rd_valid) rd_data <= mem[rd_addr];
    end
  end

  // Storage is not reset; copy and host never write in the same cycle.
  always_ff @(posedge clk) begin
    if (copy_grant) begin
      mem[cp_wr_addr] <= cp_wdata;
    end else if (wr_valid) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_byte_copy_arbiter.sv
// Directed bench for byte_copy_arbiter: copies, masking, wrap, starvation guard, host byte writes, reset mid-copy.
module tb_byte_copy_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_rvalid;
  logic        cp_start;
  logic [3:0]  cp_src, cp_dst;
  logic [4:0]  cp_len;
  logic [3:0]  cp_mask;
  logic        cp_busy, cp_done;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  byte_copy_arbiter #(.AW(4), .DW(32), .STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rvalid(rd_rvalid),
    .cp_start(cp_start), .cp_src(cp_src), .cp_dst(cp_dst), .cp_len(cp_len), .cp_mask(cp_mask),
    .cp_busy(cp_busy), .cp_done(cp_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_valid = 1'b0; wr_be = 4'h0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    rd_valid = 1'b1; rd_addr = a;
    tick();
    rd_valid = 1'b0;
    d = rd_data;
  endtask

  task automatic mem_clear;
    for (int i = 0; i < 16; i++) host_write(4'(i), 4'hF, 32'h0);
  endtask

  task automatic start_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l, input logic [3:0] m);
    cp_start = 1'b1; cp_src = s; cp_dst = d; cp_len = l; cp_mask = m;
    tick();
    cp_start = 1'b0;
  endtask

  // Returns the cycle (counted from the start cycle) at which cp_done is seen, or -1 on timeout.
  task automatic wait_done(output int done_cyc, output int busy_cyc);
    done_cyc = -1;
    busy_cyc = 0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (cp_done) begin
        done_cyc = cyc;
        return;
      end
      if (cp_busy) busy_cyc++;
      tick();
    end
  endtask

  task automatic test_reset;
    checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
    checks++; if (rd_rvalid !== 1'b0) $display("FAIL reset_rd_rvalid: got %b want 0", rd_rvalid); else passed++;
    checks++; if (cp_busy !== 1'b0) $display("FAIL reset_cp_busy: got %b want 0", cp_busy); else passed++;
    checks++; if (cp_done !== 1'b0) $display("FAIL reset_cp_done: got %b want 0", cp_done); else passed++;
  endtask

  task automatic test_plain_copy;
    int dc, bc;
    logic [31:0] d;
    mem_clear();
    for (int i = 0; i < 4; i++) host_write(4'(i), 4'hF, 32'h11111111 * i);
    start_copy(4'd0, 4'd8, 5'd4, 4'hF);
    wait_done(dc, bc);
    checks++; if (dc != 5) $display("FAIL plain_done_cycle: got %0d want 5", dc); else passed++;
    checks++; if (bc != 4) $display("FAIL plain_busy_cycles: got %0d want 4", bc); else passed++;
    tick();
    checks++; if (cp_done !== 1'b0) $display("FAIL plain_done_pulse: got %b want 0", cp_done); else passed++;
    for (int i = 0; i < 4; i++) begin
      host_read(4'(8 + i), d);
      checks++;
      if (d !== 32'h11111111 * i) $display("FAIL plain_mem%0d: got %h want %h", 8 + i, d, 32'h11111111 * i);
      else passed++;
    end
    checks++; if (rd_rvalid !== 1'b1) $display("FAIL plain_rvalid: got %b want 1", rd_rvalid); else passed++;
  endtask

  task automatic test_masked_wrap;
    int dc, bc;
    logic [31:0] d;
    mem_clear();
    host_write(4'd15, 4'hF, 32'hAABBCCDD);
    host_write(4'd0, 4'hF, 32'h01020304);
    host_write(4'd1, 4'hF, 32'hFFFFFFFF);
    host_write(4'd2, 4'hF, 32'hFFFFFFFF);
    start_copy(4'd15, 4'd1, 5'd2, 4'b0101);
    wait_done(dc, bc);
    checks++; if (dc != 3) $display("FAIL masked_done_cycle: got %0d want 3", dc); else passed++;
    tick();
    host_read(4'd1, d);
    checks++; if (d !== 32'hFFBBFFDD) $display("FAIL masked_mem1: got %h want FFBBFFDD", d); else passed++;
    host_read(4'd2, d);
    checks++; if (d !== 32'hFF02FF04) $display("FAIL masked_mem2: got %h want FF02FF04", d); else passed++;
    host_read(4'd0, d);
    checks++; if (d !== 32'h01020304) $display("FAIL masked_src_kept: got %h want 01020304", d); else passed++;
  endtask

  task automatic test_starvation;
    int acc, copy_cycles, ready_bad, seen;
    logic exp_ready;
    logic [31:0] d;
    mem_clear();
    for (int i = 1; i < 4; i++) host_write(4'(i), 4'hF, 32'h11111111 * i);
    cp_start = 1'b1; cp_src = 4'd1; cp_dst = 4'd4; cp_len = 5'd3; cp_mask = 4'hF;
    wr_valid = 1'b1; wr_addr = 4'd13; wr_be = 4'hF; wr_data = 32'h1000;
    #1;
    acc = 0; copy_cycles = 0; ready_bad = 0; seen = 0;
    for (int k = 0; k < 60; k++) begin
      exp_ready = cp_busy ? ((copy_cycles % 4) != 3) : 1'b1;
      if (wr_ready !== exp_ready) ready_bad++;
      if (wr_ready) acc++;
      if (cp_busy) copy_cycles++;
      if (cp_done) seen = 1;
      tick();
      cp_start = 1'b0;
      wr_data = 32'h1000 + 32'(acc);
      #1;
      if (seen != 0) break;
    end
    wr_valid = 1'b0;
    checks++; if (seen != 1) $display("FAIL starve_done_seen: got %0d want 1", seen); else passed++;
    checks++; if (copy_cycles != 12) $display("FAIL starve_copy_cycles: got %0d want 12", copy_cycles); else passed++;
    checks++; if (ready_bad != 0) $display("FAIL starve_ready_pattern: got %0d bad cycles want 0", ready_bad); else passed++;
    checks++; if (acc != 11) $display("FAIL starve_host_accepts: got %0d want 11", acc); else passed++;
    host_read(4'd13, d);
    checks++; if (d !== 32'h0000100A) $display("FAIL starve_host_last: got %h want 0000100A", d); else passed++;
    for (int i = 0; i < 3; i++) begin
      host_read(4'(4 + i), d);
      checks++;
      if (d !== 32'h11111111 * (i + 1)) $display("FAIL starve_mem%0d: got %h want %h", 4 + i, d, 32'h11111111 * (i + 1));
      else passed++;
    end
  endtask

  task automatic test_byte_write_rbw;
    logic [31:0] d;
    mem_clear();
    wr_valid = 1'b1; wr_addr = 4'd5; wr_be = 4'b0010; wr_data = 32'h0000AB00;
    rd_valid = 1'b1; rd_addr = 4'd5;
    tick();
    wr_valid = 1'b0; wr_be = 4'h0; rd_valid = 1'b0;
    checks++; if (rd_data !== 32'h0) $display("FAIL rbw_old_data: got %h want 0", rd_data); else passed++;
    checks++; if (rd_rvalid !== 1'b1) $display("FAIL rbw_rvalid: got %b want 1", rd_rvalid); else passed++;
    host_read(4'd5, d);
    checks++; if (d !== 32'h0000AB00) $display("FAIL rbw_new_data: got %h want 0000AB00", d); else passed++;
    tick();
    checks++; if (rd_rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %b want 0", rd_rvalid); else passed++;
    checks++; if (rd_data !== 32'h0000AB00) $display("FAIL rd_data_hold: got %h want 0000AB00", rd_data); else passed++;
    host_write(4'd5, 4'h0, 32'hFFFFFFFF);
    host_write(4'd5, 4'b1001, 32'h12345678);
    host_read(4'd5, d);
    checks++; if (d !== 32'h1200AB78) $display("FAIL be_merge: got %h want 1200AB78", d); else passed++;
  endtask

  task automatic test_zero_len_overlap;
    int dc, bc;
    logic [31:0] d;
    mem_clear();
    host_write(4'd7, 4'hF, 32'h00000077);
    start_copy(4'd0, 4'd7, 5'd0, 4'hF);
    checks++; if (cp_done !== 1'b1) $display("FAIL zero_len_done: got %b want 1", cp_done); else passed++;
    checks++; if (cp_busy !== 1'b0) $display("FAIL zero_len_busy: got %b want 0", cp_busy); else passed++;
    tick();
    checks++; if (cp_done !== 1'b0) $display("FAIL zero_len_pulse: got %b want 0", cp_done); else passed++;
    host_read(4'd7, d);
    checks++; if (d !== 32'h00000077) $display("FAIL zero_len_mem: got %h want 00000077", d); else passed++;
    host_write(4'd2, 4'hF, 32'h5A5A5A5A);
    start_copy(4'd2, 4'd3, 5'd3, 4'hF);
    wait_done(dc, bc);
    checks++; if (dc != 4) $display("FAIL overlap_done_cycle: got %0d want 4", dc); else passed++;
    tick();
    for (int i = 3; i < 6; i++) begin
      host_read(4'(i), d);
      checks++; if (d !== 32'h5A5A5A5A) $display("FAIL overlap_mem%0d: got %h want 5A5A5A5A", i, d); else passed++;
    end
    host_read(4'd6, d);
    checks++; if (d !== 32'h0) $display("FAIL overlap_mem6: got %h want 0", d); else passed++;
  endtask

  task automatic test_reset_mid_copy;
    int dc, bc, done_seen;
    logic [31:0] d;
    mem_clear();
    for (int i = 0; i < 4; i++) host_write(4'(i), 4'hF, 32'hA0A0A0A0 + 32'(i));
    start_copy(4'd0, 4'd8, 5'd4, 4'hF);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cp_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", cp_busy); else passed++;
    tick();
    #2 rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cp_done) done_seen++;
    end
    checks++; if (done_seen != 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_seen); else passed++;
    host_read(4'd8, d);
    checks++; if (d !== 32'hA0A0A0A0) $display("FAIL rst_mid_mem8: got %h want A0A0A0A0", d); else passed++;
    host_read(4'd9, d);
    checks++; if (d !== 32'h0) $display("FAIL rst_mid_mem9: got %h want 0", d); else passed++;
    start_copy(4'd1, 4'd12, 5'd1, 4'hF);
    wait_done(dc, bc);
    checks++; if (dc != 2) $display("FAIL rst_restart_done: got %0d want 2", dc); else passed++;
    tick();
    host_read(4'd12, d);
    checks++; if (d !== 32'hA0A0A0A1) $display("FAIL rst_restart_mem12: got %h want A0A0A0A1", d); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;
    cp_start = 1'b0; cp_src = '0; cp_dst = '0; cp_len = '0; cp_mask = '0;
    #12;
    test_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    test_plain_copy();
    test_masked_wrap();
    test_starvation();
    test_byte_write_rbw();
    test_zero_len_overlap();
    test_reset_mid_copy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
